// File: rtl/hilo_divider.sv
// Multi-cycle restoring radix-2 divider owning the architectural HI/LO pair.
// LO receives the quotient, HI the remainder; mthi/mtlo write them when not busy.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             signed_q, signed_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    shifted = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_neg   = signed_q & a_q[WIDTH-1];
    b_neg   = signed_q & b_q[WIDTH-1];
    // -2^(W-1) negates to itself, which is exactly its magnitude read unsigned
    a_abs   = a_neg ? -a_q : a_q;
    b_abs   = b_neg ? -b_q : b_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (!busy_q) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    if (flush && busy_q) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (start) begin
            a_d      = op_a;
            b_d      = op_b;
            signed_d = signed_op;
            state_d  = S_PREP;
            busy_d   = 1'b1;
          end
        end
        S_PREP: begin
          if (b_q == '0) begin
            hi_d    = a_q;
            lo_d    = '1;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            q_d     = a_abs;
            b_d     = b_abs;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CW'(WIDTH);
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          if (shifted >= {1'b0, b_q}) begin
            rem_d = shifted - {1'b0, b_q};
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted;
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          lo_d    = qneg_q ? -q_q : q_q;
          hi_d    = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider: results, latency, flush, reset, mthi/mtlo.
module tb_hilo_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one division from IDLE/DONE and returns cycles until done (start edge = 1).
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    start = 1'b1; signed_op = s; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
    tick();
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_unsigned();
    int lat;
    run_div(1'b0, 32'd100, 32'd7, lat);
    $display("divu 100/7: lat=%0d lo=%0d hi=%0d dbz=%b", lat, lo, hi, div_by_zero);
    checks += 5;
    if (lat !== 35) begin errors++; $display("FAIL divu_latency got %0d want 35", lat); end
    if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %0d want 14", lo); end
    if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %0d want 2", hi); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dbz got %b want 0", div_by_zero); end
    if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_in_done got %b want 0", busy); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_signed();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    int lat;
    va = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9};
    vb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
    eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    er = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_div(1'b1, va[i], vb[i], lat);
      $display("div %h/%h: lat=%0d lo=%h hi=%h", va[i], vb[i], lat, lo, hi);
      checks += 3;
      if (lat !== 35) begin errors++; $display("FAIL div_latency[%0d] got %0d want 35", i, lat); end
      if (lo !== eq[i]) begin errors++; $display("FAIL div_lo[%0d] got %h want %h", i, lo, eq[i]); end
      if (hi !== er[i]) begin errors++; $display("FAIL div_hi[%0d] got %h want %h", i, hi, er[i]); end
    end
  endtask

  task automatic test_edge();
    logic        vs [3];
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    int lat;
    vs = '{1'b1,          1'b0,          1'b0};
    va = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vb = '{32'hFFFF_FFFF, 32'd1,         32'd2};
    eq = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    er = '{32'h0,         32'h0,         32'd1};
    for (int i = 0; i < 3; i++) begin
      run_div(vs[i], va[i], vb[i], lat);
      $display("edge s=%b %h/%h: lo=%h hi=%h dbz=%b", vs[i], va[i], vb[i], lo, hi, div_by_zero);
      checks += 3;
      if (lo !== eq[i]) begin errors++; $display("FAIL edge_lo[%0d] got %h want %h", i, lo, eq[i]); end
      if (hi !== er[i]) begin errors++; $display("FAIL edge_hi[%0d] got %h want %h", i, hi, er[i]); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL edge_dbz[%0d] got %b want 0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_div(1'b0, 32'd123, 32'd0, lat);
    $display("divu 123/0: lat=%0d lo=%h hi=%0d dbz=%b", lat, lo, hi, div_by_zero);
    checks += 4;
    if (lat !== 2) begin errors++; $display("FAIL dbz_latency got %0d want 2", lat); end
    if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
    if (hi !== 32'd123) begin errors++; $display("FAIL dbz_hi got %0d want 123", hi); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat);
    $display("div -5/0: lat=%0d lo=%h hi=%h dbz=%b", lat, lo, hi, div_by_zero);
    checks += 2;
    if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dbz_signed_hi got %h want fffffffb", hi); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_signed_flag got %b want 1", div_by_zero); end
    run_div(1'b0, 32'd10, 32'd3, lat);
    $display("divu 10/3 after dbz: lo=%0d hi=%0d dbz=%b", lo, hi, div_by_zero);
    checks += 3;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
    if (lo !== 32'd3) begin errors++; $display("FAIL dbz_next_lo got %0d want 3", lo); end
    if (hi !== 32'd1) begin errors++; $display("FAIL dbz_next_hi got %0d want 1", hi); end
  endtask

  task automatic test_control();
    int lat;
    int seen;
    start = 1'b1; signed_op = 1'b0; op_a = 32'd100; op_b = 32'd7;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_iter got %b want 1", busy); end
        start = 1'b1; op_a = 32'd9; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    $display("ignored start: lat=%0d lo=%0d hi=%0d", lat, lo, hi);
    checks += 3;
    if (lat !== 35) begin errors++; $display("FAIL ignore_latency got %0d want 35", lat); end
    if (lo !== 32'd14) begin errors++; $display("FAIL ignore_lo got %0d want 14", lo); end
    if (hi !== 32'd2) begin errors++; $display("FAIL ignore_hi got %0d want 2", hi); end

    start = 1'b1; op_a = 32'd55; op_b = 32'd5;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 5) begin tick(); lat++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    $display("flush: busy=%b done_seen=%0d lo=%0d hi=%0d", busy, seen, lo, hi);
    checks += 3;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", seen); end
    if (lo !== 32'd14) begin errors++; $display("FAIL flush_lo got %0d want 14", lo); end
    if (hi !== 32'd2) begin errors++; $display("FAIL flush_hi got %0d want 2", hi); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_div(1'b0, 32'd100, 32'd7, lat);
    run_div(1'b1, 32'hFFFF_FFEC, 32'd6, lat);
    $display("back-to-back -20/6: lat=%0d lo=%h hi=%h", lat, lo, hi);
    checks += 3;
    if (lat !== 35) begin errors++; $display("FAIL b2b_latency got %0d want 35", lat); end
    if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_lo got %h want fffffffd", lo); end
    if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_hi got %h want fffffffe", hi); end
  endtask

  task automatic test_writes();
    int lat;
    int seen;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    lo_we = 1'b0; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    checks++;
    if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo got %h want deadbeef", lo); end
    tick();
    hi_we = 1'b0;
    $display("mtlo/mthi: lo=%h hi=%h", lo, hi);
    checks += 2;
    if (hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL mthi got %h want cafef00d", hi); end
    if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_keeps_lo got %h want deadbeef", lo); end

    start = 1'b1; signed_op = 1'b0; op_a = 32'd100; op_b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    lo_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_busy got %h want deadbeef", lo); end
    lat = 3;
    while (!done && lat < 100) begin tick(); lat++; end
    $display("div after busy mtlo: lo=%0d hi=%0d", lo, hi);
    checks++;
    if (lo !== 32'd14) begin errors++; $display("FAIL mtlo_busy_result got %0d want 14", lo); end

    tick();
    start = 1'b1; op_a = 32'd50; op_b = 32'd5; lo_we = 1'b1; wdata = 32'h11;
    tick();
    start = 1'b0; lo_we = 1'b0;
    checks += 2;
    if (lo !== 32'h11) begin errors++; $display("FAIL mtlo_with_start got %h want 11", lo); end
    if (busy !== 1'b1) begin errors++; $display("FAIL start_with_mtlo got %b want 1", busy); end
    lat = 1;
    while (lat < 10) begin tick(); lat++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("rst mid-iter: busy=%b done=%b dbz=%b hi=%h lo=%h", busy, done, div_by_zero, hi, lo);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_dbz got %b want 0", div_by_zero); end
    if (hi !== 32'h0) begin errors++; $display("FAIL rst_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("FAIL rst_lo got %h want 0", lo); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", seen); end
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] a, b, eq, er;
    int lat;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'h0) b = 32'd3;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      if (s) begin
        eq = 32'($signed(a) / $signed(b));
        er = 32'($signed(a) % $signed(b));
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_div(s, a, b, lat);
      $display("rand[%0d] s=%b %h/%h: lo=%h hi=%h", i, s, a, b, lo, hi);
      checks += 2;
      if (lo !== eq) begin errors++; $display("FAIL rand_lo[%0d] got %h want %h", i, lo, eq); end
      if (hi !== er) begin errors++; $display("FAIL rand_hi[%0d] got %h want %h", i, hi, er); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_edge();
    test_div_zero();
    test_control();
    test_back_to_back();
    test_writes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
